// File: rtl/invader_march_ctrl.sv
// Formation march controller: turns quarter-second ticks into formation offsets,
// direction, animation frame and a step pulse, speeding up as invaders die.
module invader_march_ctrl #(
  parameter int unsigned COL_PITCH = 32,
  parameter int unsigned STEP_X    = 8,
  parameter int unsigned STEP_Y    = 16,
  parameter int unsigned X_INIT    = 64,
  parameter int unsigned Y_INIT    = 48,
  parameter int unsigned X_LIMIT   = 640,
  parameter int unsigned Y_LIMIT   = 400
) (
  input  logic       CLK,
  input  logic       Rst,
  input  logic       Clr,
  input  logic       EN,
  input  logic       Tick,
  input  logic [5:0] AliveCnt,
  input  logic [2:0] ColL,
  input  logic [2:0] ColR,
  output logic [9:0] XOff,
  output logic [8:0] YOff,
  output logic       Dir,
  output logic       Frame,
  output logic       Step,
  output logic       Landed,
  output logic       WaveClr
);

  localparam int unsigned XW  = 10;
  localparam int unsigned YW  = 9;
  localparam int unsigned YDW = YW + 1;
  localparam int unsigned EW  = 11;
  localparam int unsigned CW  = 3;
  localparam int unsigned NW  = CW + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MARCH   = 3'd1,
    S_HOLD    = 3'd2,
    S_LANDED  = 3'd3,
    S_CLEARED = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   xoff_q, xoff_d;
  logic [YW-1:0]   yoff_q, yoff_d;
  logic            dir_q, dir_d;
  logic            frame_q, frame_d;
  logic            step_q, step_d;
  logic            landed_q, landed_d;
  logic            wave_clr_q, wave_clr_d;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;

  logic [EW-1:0]   left_edge_c;
  logic [EW-1:0]   right_edge_c;
  logic            drop_c;
  logic [YDW-1:0]  y_drop_c;
  logic [NW-1:0]   need_c;
  logic [NW-1:0]   tick_sum_c;

  // Formation edges in 11 bits so the limit compares never wrap
  assign left_edge_c  = EW'(xoff_q) + EW'(ColL) * EW'(COL_PITCH);
  assign right_edge_c = EW'(xoff_q) + (EW'(ColR) + EW'(1)) * EW'(COL_PITCH);
  assign drop_c       = dir_q ? ((right_edge_c + EW'(STEP_X)) > EW'(X_LIMIT))
                              : (left_edge_c < EW'(STEP_X));
  assign y_drop_c     = YDW'(yoff_q) + YDW'(STEP_Y);
  assign need_c       = {1'b0, AliveCnt[5:3]} + NW'(1);
  assign tick_sum_c   = {1'b0, tick_cnt_q} + NW'(1);

  always_comb begin
    state_d    = state_q;
    xoff_d     = xoff_q;
    yoff_d     = yoff_q;
    dir_d      = dir_q;
    frame_d    = frame_q;
    step_d     = 1'b0;
    landed_d   = landed_q;
    wave_clr_d = wave_clr_q;
    tick_cnt_d = tick_cnt_q;

    if (Clr) begin
      state_d    = S_IDLE;
      xoff_d     = XW'(X_INIT);
      yoff_d     = YW'(Y_INIT);
      dir_d      = 1'b1;
      frame_d    = 1'b0;
      landed_d   = 1'b0;
      wave_clr_d = 1'b0;
      tick_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (EN) state_d = S_MARCH;
        end
        S_MARCH: begin
          if (AliveCnt == 6'd0) begin
            state_d    = S_CLEARED;
            wave_clr_d = 1'b1;
          end else if (!EN) begin
            state_d = S_HOLD;
          end else if (Tick) begin
            if (tick_sum_c >= need_c) begin
              tick_cnt_d = '0;
              step_d     = 1'b1;
              frame_d    = ~frame_q;
              if (drop_c) begin
                yoff_d = YW'(y_drop_c);
                dir_d  = ~dir_q;
                if (y_drop_c >= YDW'(Y_LIMIT)) begin
                  state_d  = S_LANDED;
                  landed_d = 1'b1;
                end
              end else if (dir_q) begin
                xoff_d = xoff_q + XW'(STEP_X);
              end else begin
                xoff_d = xoff_q - XW'(STEP_X);
              end
            end else begin
              tick_cnt_d = tick_cnt_q + CW'(1);
            end
          end
        end
        S_HOLD: begin
          if (AliveCnt == 6'd0) begin
            state_d    = S_CLEARED;
            wave_clr_d = 1'b1;
          end else if (EN) begin
            state_d = S_MARCH;
          end
        end
        S_LANDED, S_CLEARED: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      xoff_q     <= XW'(X_INIT);
      yoff_q     <= YW'(Y_INIT);
      dir_q      <= 1'b1;
      frame_q    <= 1'b0;
      step_q     <= 1'b0;
      landed_q   <= 1'b0;
      wave_clr_q <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      xoff_q     <= xoff_d;
      yoff_q     <= yoff_d;
      dir_q      <= dir_d;
      frame_q    <= frame_d;
      step_q     <= step_d;
      landed_q   <= landed_d;
      wave_clr_q <= wave_clr_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign XOff    = xoff_q;
  assign YOff    = yoff_q;
  assign Dir     = dir_q;
  assign Frame   = frame_q;
  assign Step    = step_q;
  assign Landed  = landed_q;
  assign WaveClr = wave_clr_q;

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Bench for invader_march_ctrl: vector table, hand corner sequences and a
// randomized run against a behavioural march model.
module tb_invader_march_ctrl;

  logic       CLK, Rst, Clr, EN, Tick;
  logic [5:0] AliveCnt;
  logic [2:0] ColL, ColR;
  logic [9:0] XOff, XOff2;
  logic [8:0] YOff, YOff2;
  logic       Dir, Frame, Step, Landed, WaveClr;
  logic       Dir2, Frame2, Step2, Landed2, WaveClr2;

  int n_asserts = 0;
  int n_fail    = 0;

  invader_march_ctrl dut (
    .CLK(CLK), .Rst(Rst), .Clr(Clr), .EN(EN), .Tick(Tick),
    .AliveCnt(AliveCnt), .ColL(ColL), .ColR(ColR),
    .XOff(XOff), .YOff(YOff), .Dir(Dir), .Frame(Frame), .Step(Step),
    .Landed(Landed), .WaveClr(WaveClr)
  );

  invader_march_ctrl #(.Y_LIMIT(80)) dut_low (
    .CLK(CLK), .Rst(Rst), .Clr(Clr), .EN(EN), .Tick(Tick),
    .AliveCnt(AliveCnt), .ColL(ColL), .ColR(ColR),
    .XOff(XOff2), .YOff(YOff2), .Dir(Dir2), .Frame(Frame2), .Step(Step2),
    .Landed(Landed2), .WaveClr(WaveClr2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_asserts++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Behavioural model: plain integers, one call per clock
  int m_x, m_y, m_dir, m_frame, m_step, m_land, m_wclr, m_cnt;
  int m_mode; // 0 waiting, 1 marching, 2 paused, 3 finished

  task automatic model_reset();
    m_x = 64; m_y = 48; m_dir = 1; m_frame = 0; m_step = 0;
    m_land = 0; m_wclr = 0; m_cnt = 0; m_mode = 0;
  endtask

  task automatic model_move(input int coll, input int colr);
    int left, right;
    left  = m_x + coll * 32;
    right = m_x + (colr + 1) * 32;
    if ((m_dir == 1 && right + 8 > 640) || (m_dir == 0 && left < 8)) begin
      m_y   = m_y + 16;
      m_dir = 1 - m_dir;
      if (m_y >= 400) begin
        m_mode = 3;
        m_land = 1;
      end
    end else begin
      m_x = (m_dir == 1) ? (m_x + 8) % 1024 : (m_x + 1024 - 8) % 1024;
    end
    m_step  = 1;
    m_frame = 1 - m_frame;
  endtask

  task automatic model_step(input bit clr, input bit en, input bit tick,
                            input int alive, input int coll, input int colr);
    m_step = 0;
    if (clr) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (alive == 0) begin
        m_mode = 3;
        m_wclr = 1;
      end else if (m_mode == 2) begin
        if (en) m_mode = 1;
      end else if (!en) begin
        m_mode = 2;
      end else if (tick) begin
        m_cnt++;
        if (m_cnt >= alive / 8 + 1) begin
          m_cnt = 0;
          model_move(coll, colr);
        end
      end
    end
  endtask

  typedef struct {
    bit clr, en, tick;
    int alive;
    int x, y, dir, frame, step, wclr;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input int rep, input bit clr, input bit en, input bit tick,
                              input int alive, input int x, input int y, input int dir,
                              input int frame, input int step, input int wclr);
    vec_t v;
    v.clr = clr; v.en = en; v.tick = tick; v.alive = alive;
    v.x = x; v.y = y; v.dir = dir; v.frame = frame; v.step = step; v.wclr = wclr;
    for (int r = 0; r < rep; r++) vq.push_back(v);
  endfunction

  initial begin
    int ticks_used;
    int x_hold;
    int alive_r, coll_r, colr_r;

    add(1, 0, 1, 0, 5,   64, 48, 1, 0, 0, 0);
    add(1, 0, 1, 1, 5,   72, 48, 1, 1, 1, 0);
    add(1, 0, 1, 0, 5,   72, 48, 1, 1, 0, 0);
    add(5, 0, 1, 1, 40,  72, 48, 1, 1, 0, 0);
    add(1, 0, 1, 1, 40,  80, 48, 1, 0, 1, 0);
    add(1, 0, 1, 1, 7,   88, 48, 1, 1, 1, 0);
    add(1, 0, 1, 1, 7,   96, 48, 1, 0, 1, 0);
    add(1, 0, 1, 0, 40,  96, 48, 1, 0, 0, 0);
    add(3, 0, 1, 1, 40,  96, 48, 1, 0, 0, 0);
    add(1, 0, 0, 1, 40,  96, 48, 1, 0, 0, 0);
    add(10, 0, 0, 1, 40, 96, 48, 1, 0, 0, 0);
    add(1, 0, 1, 0, 40,  96, 48, 1, 0, 0, 0);
    add(2, 0, 1, 1, 40,  96, 48, 1, 0, 0, 0);
    add(1, 0, 1, 1, 40, 104, 48, 1, 1, 1, 0);
    add(1, 1, 1, 1, 40,  64, 48, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0,   64, 48, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0,   64, 48, 1, 0, 0, 1);
    add(1, 0, 1, 1, 5,   64, 48, 1, 0, 0, 1);
    add(1, 1, 0, 0, 5,   64, 48, 1, 0, 0, 0);

    Rst = 1'b1; Clr = 1'b0; EN = 1'b0; Tick = 1'b0;
    AliveCnt = 6'd5; ColL = 3'd0; ColR = 3'd7;
    #3 Rst = 1'b0;
    #2;
    chk("reset.x", int'(XOff), 64);
    chk("reset.y", int'(YOff), 48);
    chk("reset.dir", int'(Dir), 1);
    chk("reset.frame", int'(Frame), 0);
    chk("reset.step", int'(Step), 0);
    chk("reset.landed", int'(Landed), 0);
    chk("reset.wclr", int'(WaveClr), 0);
    #7 Rst = 1'b1;

    // Table of single-cycle vectors
    for (int i = 0; i < vq.size(); i++) begin
      Clr = vq[i].clr; EN = vq[i].en; Tick = vq[i].tick;
      AliveCnt = 6'(vq[i].alive);
      cyc();
      chk($sformatf("vec%0d.x", i), int'(XOff), vq[i].x);
      chk($sformatf("vec%0d.y", i), int'(YOff), vq[i].y);
      chk($sformatf("vec%0d.dir", i), int'(Dir), vq[i].dir);
      chk($sformatf("vec%0d.frame", i), int'(Frame), vq[i].frame);
      chk($sformatf("vec%0d.step", i), int'(Step), vq[i].step);
      chk($sformatf("vec%0d.wclr", i), int'(WaveClr), vq[i].wclr);
    end

    // Right-edge drop after 40 steps, then reversal
    Clr = 1'b0; EN = 1'b1; Tick = 1'b0; AliveCnt = 6'd5;
    cyc();
    for (int t = 1; t <= 42; t++) begin
      Tick = 1'b1;
      cyc();
      if (t == 40) chk("edge.t40.x", int'(XOff), 384);
      if (t == 41) begin
        chk("edge.t41.x", int'(XOff), 384);
        chk("edge.t41.y", int'(YOff), 64);
        chk("edge.t41.dir", int'(Dir), 0);
        chk("edge.t41.step", int'(Step), 1);
      end
      if (t == 42) chk("edge.t42.x", int'(XOff), 376);
    end
    Tick = 1'b0;

    // Asynchronous reset mid-march, checked before any clock edge
    #2 Rst = 1'b0;
    #1;
    chk("amid.x", int'(XOff), 64);
    chk("amid.y", int'(YOff), 48);
    chk("amid.dir", int'(Dir), 1);
    chk("amid.step", int'(Step), 0);
    chk("amid.landed", int'(Landed), 0);
    cyc();
    #2 Rst = 1'b1;

    // Landing on the low-limit instance: 41 ticks to first drop, 49 more to the second
    cyc();
    ticks_used = 0;
    Tick = 1'b1;
    while (!Landed2 && ticks_used < 200) begin
      cyc();
      ticks_used++;
    end
    chk("land.ticks", ticks_used, 90);
    chk("land.y", int'(YOff2), 80);
    chk("land.flag", int'(Landed2), 1);
    chk("land.dir", int'(Dir2), 1);
    chk("land.step", int'(Step2), 1);
    chk("noland.flag", int'(Landed), 0);
    chk("noland.y", int'(YOff), 80);
    x_hold = int'(XOff2);
    for (int t = 0; t < 5; t++) cyc();
    chk("land.freeze.x", int'(XOff2), x_hold);
    chk("land.freeze.y", int'(YOff2), 80);
    chk("land.freeze.step", int'(Step2), 0);
    chk("land.freeze.flag", int'(Landed2), 1);
    Clr = 1'b1;
    cyc();
    chk("land.clr.flag", int'(Landed2), 0);
    chk("land.clr.y", int'(YOff2), 48);
    chk("land.clr.step", int'(Step2), 0);

    // Randomized run against the model
    model_reset();
    alive_r = 12; coll_r = 0; colr_r = 7;
    for (int c = 0; c < 4000; c++) begin
      Clr  = (c == 0) || ($urandom % 1000 == 0);
      EN   = ($urandom % 16) != 0;
      Tick = ($urandom % 2) == 1;
      if ($urandom % 100 == 0)
        alive_r = ($urandom % 20 == 0) ? 0 : 1 + int'($urandom % 23);
      if ($urandom % 150 == 0) begin
        coll_r = int'($urandom % 8);
        colr_r = coll_r + int'($urandom % (8 - coll_r));
      end
      AliveCnt = 6'(alive_r); ColL = 3'(coll_r); ColR = 3'(colr_r);
      model_step(Clr, EN, Tick, alive_r, coll_r, colr_r);
      cyc();
      chk("rnd.x", int'(XOff), m_x);
      chk("rnd.y", int'(YOff), m_y);
      chk("rnd.dir", int'(Dir), m_dir);
      chk("rnd.frame", int'(Frame), m_frame);
      chk("rnd.step", int'(Step), m_step);
      chk("rnd.landed", int'(Landed), m_land);
      chk("rnd.wclr", int'(WaveClr), m_wclr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
